// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: address/instruction words and the queued entry.
package fetch_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] instr_t;

  typedef struct packed {
    instr_t instr;
    addr_t  pc;
  } fetch_entry_t;

  localparam int unsigned INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_if.sv
// Fetch bus bundle: imem request/response, branch redirect from execute, and the decode handshake.
interface fetch_if;
  import fetch_pkg::*;

  logic   imem_req;
  addr_t  imem_addr;
  logic   imem_gnt;
  logic   imem_rvalid;
  instr_t imem_rdata;
  logic   redirect;
  addr_t  redirect_target;
  logic   instr_valid;
  instr_t instr;
  addr_t  instr_pc;
  logic   instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_target, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_target, instr_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch entries; head is read straight from storage flops, flush beats push/pop.
// Push and pop in one cycle are both honoured; the caller reserves space, so push is dropped only if truly full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       head_vld,
  output fetch_entry_t               head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_vld = (count_q != '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, keeps up to MAX_OUTSTANDING imem reads in flight, buffers words for decode.
// First instr_valid 2 cycles after the first request on zero-wait memory; FETCH_STATS_EN adds fetch/discard counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int    DEPTH           = 4,
  parameter int    MAX_OUTSTANDING = 2,
  parameter addr_t RESET_VECTOR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  fetch_if.master     bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [15:0] stat_discarded
`endif
);
  localparam int    OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int    CW   = $clog2(DEPTH + 1);
  localparam addr_t STEP = addr_t'(INSTR_BYTES);

  addr_t        fetch_pc_q, fetch_pc_d;
  addr_t        resp_pc_q, resp_pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [CW-1:0] occupancy;
  logic [31:0]  inflight;
  logic         req, accept, rsp, drop, push, pop, head_vld;
  addr_t        target;
  fetch_entry_t push_dat, head_dat;

  always_comb begin
    inflight = 32'(outstanding_q) + 32'(occupancy);
    // Queue slots are reserved at issue time so a returning word always has room.
    req      = !reset && !bus.redirect
               && (32'(outstanding_q) < 32'(MAX_OUTSTANDING))
               && (inflight < 32'(DEPTH));
    accept   = req && bus.imem_gnt;
    rsp      = bus.imem_rvalid;
    drop     = rsp && (bus.redirect || (discard_q != '0));
    push     = rsp && !drop;
    pop      = head_vld && bus.instr_ready && !bus.redirect;
    target   = bus.redirect_target & 32'hFFFF_FFFC;
    push_dat = '{instr: bus.imem_rdata, pc: resp_pc_q};
  end

  always_comb begin
    outstanding_d = outstanding_q + OW'(accept) - OW'(rsp);
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    if (bus.redirect) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      // Everything still in flight after this cycle belongs to the old stream.
      discard_d  = outstanding_d;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + STEP;
      if (push) resp_pc_d = resp_pc_q + STEP;
      if (rsp && (discard_q != '0)) discard_d = discard_q - OW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_VECTOR;
      resp_pc_q     <= RESET_VECTOR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (bus.redirect),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .count    (occupancy)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = head_vld;
  assign bus.instr       = head_dat.instr;
  assign bus.instr_pc    = head_dat.pc;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [15:0] stat_discarded_q, stat_discarded_d;

  always_comb begin
    stat_fetched_d   = stat_fetched_q;
    stat_discarded_d = stat_discarded_q;
    if (pop && (stat_fetched_q != '1)) stat_fetched_d = stat_fetched_q + 32'd1;
    if (drop && (stat_discarded_q != '1)) stat_discarded_d = stat_discarded_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetched_q   <= '0;
      stat_discarded_q <= '0;
    end else begin
      stat_fetched_q   <= stat_fetched_d;
      stat_discarded_q <= stat_discarded_d;
    end
  end

  assign stat_fetched   = stat_fetched_q;
  assign stat_discarded = stat_discarded_q;
`endif
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end: produces the instruction stream that the controller/decoder consumes, and takes the branch outcome (pcsrc plus target) back from the execute side.
- Owns the PC, issues word reads to instruction memory, and buffers returned words in a small prefetch queue.
- Presents one instruction and its PC per cycle to decode under a valid/ready handshake.
- Flushes the queue and redirects fetch whenever a taken branch or PC write is reported.

Parameters:
DEPTH, 4, prefetch queue entries; power of 2, minimum 2
MAX_OUTSTANDING, 2, maximum accepted-but-unreturned imem requests; 1..DEPTH
RESET_VECTOR, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high
imem_req  output  1  read request
imem_addr  output  32  word address of request, equal to fetch_pc
imem_gnt  input  1  request accepted this cycle when imem_req & imem_gnt
imem_rvalid  input  1  read data returned; responses arrive in request order, at least 1 cycle after grant
imem_rdata  input  32  returned instruction word
redirect  input  1  taken branch / PC write (pcsrc from controller)
redirect_target  input  32  new fetch address, word aligned
instr_valid  output  1  queue head valid
instr  output  32  queue head instruction
instr_pc  output  32  address of instr
instr_ready  input  1  decode consumes head when instr_valid & instr_ready

Behaviour:
- Reset (async assert): fetch_pc = resp_pc = RESET_VECTOR, queue empty, outstanding = 0, discard = 0, imem_req = 0, instr_valid = 0. Deassertion is synchronised externally. imem must be reset by the same signal, so no pre-reset response arrives after release.
- Issue: imem_req = !redirect & (outstanding < MAX_OUTSTANDING) & (outstanding + occupancy < DEPTH). Queue space is thereby reserved at issue, so the queue never overflows. On accept: fetch_pc += 4 (wraps modulo 2^32), outstanding += 1.
- Response: each imem_rvalid decrements outstanding.
  - If discard > 0: discard -= 1 and the data is dropped.
  - Otherwise push {imem_rdata, resp_pc}, then resp_pc += 4 (wrapping).
  - Accept and response in the same cycle: outstanding is unchanged.
- Output: instr/instr_pc/instr_valid come directly from the queue head register (no combinational path from imem). Pop on instr_valid & instr_ready. Push and pop in the same cycle are both honoured, including when the queue is full or empty.
- Latency: zero-wait memory (gnt same cycle, rvalid next cycle) gives instr_valid 2 cycles after the first request. Sustained throughput is 1 instruction/cycle when MAX_OUTSTANDING >= 2.
- Redirect (single cycle, highest priority):
  - Queue flushed, and any same-cycle pop or push is ignored.
  - imem_req forced 0.
  - fetch_pc = resp_pc = redirect_target.
  - discard = outstanding after this cycle's rvalid is accounted for (an rvalid in the redirect cycle is itself dropped).
  - Fetch resumes the next cycle.
  - A redirect while discard > 0 recomputes discard the same way.
  - Back-to-back redirects: the last one wins.
- instr_valid is 0 in the cycle after a redirect; no pre-redirect instruction is ever presented after a redirect.
- Counters: outstanding and discard are clog2(MAX_OUTSTANDING+1) bits; occupancy is clog2(DEPTH+1) bits.
- Misaligned redirect_target: bits [1:0] are forced to 0.

Optional Feature:
FETCH_STATS_EN:
- Defined: adds outputs stat_fetched (32 bits, increments per pop) and stat_discarded (16 bits, increments per dropped response). Both saturate at all-ones and clear on reset.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - addr_t (32-bit) and instr_t (32-bit)
  - fetch_entry_t struct {instr_t instr; addr_t pc;}
  - constant INSTR_BYTES = 4
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push/pop/flush, count output, and registered head. Pointers wrap modulo DEPTH.

Test Plan:
- Zero-wait memory, instr_ready=1, rdata=pc: after reset, pairs (pc, instr) = (0,0),(4,4),(8,8)… one per cycle from cycle 2.
- instr_ready=0 for 10 cycles: exactly DEPTH=4 entries buffered, imem_req drops to 0, no overflow. Raising ready drains 0,4,8,12 in order.
- Memory latency 3 with 2 outstanding, redirect to 0x100: both in-flight responses dropped (stat_discarded=2 with FETCH_STATS_EN), then first presented instr_pc = 0x100.
- Redirect in the same cycle as rvalid and a pop: the head is not consumed, the response is dropped, and the queue is empty the next cycle.
- fetch_pc = 0xFFFF_FFFC: the next request address wraps to 0x0000_0000.
- Assert reset with 2 outstanding and a full queue: all outputs are 0 immediately (asynchronous); after release, the first imem_addr = RESET_VECTOR.
